edge_frame_collector: RTL and testbench
=======================================

Name: edge_frame_collector

Overview:
- Output-side counterpart of the edge detector: captures the processed pixel stream (pixel + valid, no backpressure) into an on-chip frame buffer.
- Exposes that buffer plus control/status over an Avalon-MM slave so the host (Nios/HPS) can read the filtered image back.
- Sits between the edge detector's ProcessedImagePixel/valid outputs and the system interconnect.

Parameters:
- IMG_X_SIZE, 100, processed image width in pixels.
- IMG_Y_SIZE, 100, processed image height in pixels.
- AV_ADDR_W, 14, Avalon word-address width; must satisfy 2^AV_ADDR_W >= 4 + ceil(IMG_X_SIZE*IMG_Y_SIZE/4).

Ports:
- clk_i  in  1  single system clock.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  hardware arm strobe, same meaning as CTRL.arm.
- pixelValid_i  in  1  qualifies pixel_i; one pixel per asserted cycle.
- pixel_i  in  8  processed grey pixel.
- avs_address_i  in  AV_ADDR_W  word address.
- avs_read_i  in  1  read request.
- avs_write_i  in  1  write request.
- avs_writedata_i  in  32  write data.
- avs_readdata_o  out  32  read data.
- avs_readdatavalid_o  out  1  read data valid, fixed latency 1.
- avs_waitrequest_o  out  1  tied 0; all accesses accepted immediately.
- busy_o  out  1  high while in CAPTURE.
- irq_o  out  1  level interrupt = done & irqEn.

Behaviour:
- Reset values: all outputs 0; state IDLE; count 0; done, overrun, irqEn all 0. RAM contents are not reset.
- FSM states: IDLE, CAPTURE, DONE.
  - Arm (start_i, or write CTRL bit0=1) from any state -> CAPTURE, clears count, done and overrun.
  - CAPTURE: each pixelValid_i writes pixel_i to byte address count (word count>>2, lane count[1:0], little-endian) and increments count.
  - Pixel with count == N-1 (N = IMG_X_SIZE*IMG_Y_SIZE) -> DONE; done set on the cycle after the last write.
  - Abort (write CTRL bit1=1) in CAPTURE -> IDLE; count is kept.
  - Arm and abort in the same write: arm wins.
- pixelValid_i in IDLE or DONE: pixel dropped, overrun sticky set, count unchanged.
- Arm in the same cycle as pixelValid_i: restart takes effect first; that pixel is stored at address 0 and count becomes 1.
- Register map (word addresses):
  - 0 CTRL (W): bit0 arm, bit1 abort, bit2 clear done/overrun, bit3 irqEn (stored).
  - 0 STATUS (R): bit0 busy, bit1 done, bit2 overrun, bit3 irqEn, bits[31:16] count.
  - 1 SIZE (R): {IMG_Y_SIZE[15:0], IMG_X_SIZE[15:0]}.
  - 2-3: reserved, read 0.
  - 4 .. 4+ceil(N/4)-1: pixel words.
  - Beyond the pixel words: read 0.
- Writes to any address other than 0 are ignored.
- Reads: readdatavalid one cycle after avs_read_i with the matching data; back-to-back reads give one result per cycle.
- Read/write on the same RAM word in one cycle returns the old word (read-before-write).
- Read and write asserted together: the write is performed, the read is serviced.
- Unfilled byte lanes of the last word (N not a multiple of 4) read as stale RAM contents; software masks them.
- count width = clog2(N+1); it never wraps because CAPTURE exits at N.
- Reset asserted mid-frame returns immediately to the reset values; RAM keeps partial data.

Decomposition:
- Package edge_collector_pkg: state encoding (IDLE/CAPTURE/DONE), register word offsets (CTRL/STATUS=0, SIZE=1, PIX_BASE=4), CTRL/STATUS bit positions.
- One sub-module: frame_ram_sdp, a simple dual-port RAM, 32-bit wide, with 4 byte-enables on the write port and a registered read port (latency 1), depth ceil(N/4).

Test Plan (IMG_X_SIZE=4, IMG_Y_SIZE=4, N=16):
- Reset, then read addr 0 and addr 1 -> STATUS 0x00000000, SIZE 0x00040004, each readdatavalid exactly 1 cycle after read.
- Write CTRL=0x9 (arm, irqEn), stream pixels 0x00..0x0F on consecutive cycles -> busy_o high for 16 cycles, then STATUS=0x0010000A, irq_o=1; addr 4 reads 0x03020100, addr 7 reads 0x0F0E0D0C.
- In DONE, send 2 more pixels with valid -> overrun bit set (STATUS=0x0010000E), pixel words unchanged; write CTRL=0x4 -> STATUS=0x00100008, irq_o=0.
- Arm, send 5 pixels, write CTRL=0x2 -> state IDLE, STATUS=0x00050008; re-arm -> count 0, busy 1.
- Stream pixels with valid gaps while issuing back-to-back reads of addr 4..7 -> capture data matches the reference model, one readdatavalid per read, no lost pixels.
- Assert rst_i low at pixel 7 of a frame -> all outputs 0 asynchronously; after release STATUS=0; arm and capture a full frame -> correct data.

Source files
------------

// File: rtl/edge_collector_pkg.sv
// Shared constants for the edge frame collector: FSM encoding, register
// word offsets and bit positions of the CTRL/STATUS registers.
package edge_collector_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 0;
    localparam int REG_SIZE   = 1;
    localparam int PIX_BASE   = 4;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLEAR = 2;
    localparam int CTRL_IRQEN = 3;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_DONE      = 1;
    localparam int STATUS_OVERRUN   = 2;
    localparam int STATUS_IRQEN     = 3;
    localparam int STATUS_COUNT_LSB = 16;

    // Four 8-bit pixels are packed little-endian into each 32-bit word.
    function automatic int wordsFor(input int pixels);
        return (pixels + 3) / 4;
    endfunction

endpackage

// File: rtl/frame_ram_sdp.sv
// Simple dual-port frame RAM: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old word.
module frame_ram_sdp #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [3:0]    byteEn,
    input  logic [31:0]   wrData,
    input  logic          rdEn,
    input  logic [AW-1:0] rdAddr,
    output logic [31:0]   rdData
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[wrAddr][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/edge_frame_collector.sv
// Captures the processed pixel stream into an on-chip frame buffer and
// exposes buffer, control and status to the host over an Avalon-MM slave.
module edge_frame_collector
    import edge_collector_pkg::*;
#(
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100,
    parameter int AV_ADDR_W  = 14
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 pixelValid_i,
    input  logic [7:0]           pixel_i,
    input  logic [AV_ADDR_W-1:0] avs_address_i,
    input  logic                 avs_read_i,
    input  logic                 avs_write_i,
    input  logic [31:0]          avs_writedata_i,
    output logic [31:0]          avs_readdata_o,
    output logic                 avs_readdatavalid_o,
    output logic                 avs_waitrequest_o,
    output logic                 busy_o,
    output logic                 irq_o
);

    localparam int N      = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int DEPTH  = wordsFor(N);
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = $clog2(N + 1);

    localparam logic [CW-1:0]        LAST_PIX  = CW'(N - 1);
    localparam logic [AV_ADDR_W-1:0] ADDR_CTRL = AV_ADDR_W'(REG_CTRL);
    localparam logic [AV_ADDR_W-1:0] ADDR_STAT = AV_ADDR_W'(REG_STATUS);
    localparam logic [AV_ADDR_W-1:0] ADDR_SIZE = AV_ADDR_W'(REG_SIZE);
    localparam logic [AV_ADDR_W-1:0] ADDR_PIX  = AV_ADDR_W'(PIX_BASE);
    localparam logic [AV_ADDR_W:0]   PIX_OFS   = (AV_ADDR_W+1)'(PIX_BASE);
    localparam logic [AV_ADDR_W:0]   PIX_WORDS = (AV_ADDR_W+1)'(DEPTH);
    localparam logic [31:0]          SIZE_WORD = {16'(IMG_Y_SIZE), 16'(IMG_X_SIZE)};

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          done;
    logic          overrun;
    logic          irqEn;

    logic          ctrlWrite;
    logic          arm;
    logic          abort;
    logic          clearFlags;
    logic          irqEnLoad;
    logic          capturing;
    logic          accept;
    logic [CW-1:0] wrAddr;
    logic          lastPix;

    logic [AV_ADDR_W:0] pixRel;
    logic               addrIsPix;
    logic [31:0]        statusWord;
    logic [31:0]        regMux;
    logic               readValid;
    logic               readIsPix;
    logic [31:0]        regData;
    logic [31:0]        ramData;
    logic               unusedWriteBits;

    assign unusedWriteBits = ^avs_writedata_i[31:4];

    // Command decode. Arm wins over abort; command writes (abort/clear) leave
    // irqEn alone so software can issue them without re-stating the enable.
    assign ctrlWrite  = avs_write_i && (avs_address_i == ADDR_CTRL);
    assign arm        = start_i | (ctrlWrite & avs_writedata_i[CTRL_ARM]);
    assign abort      = ctrlWrite & avs_writedata_i[CTRL_ABORT] & ~arm & (state == ST_CAPTURE);
    assign clearFlags = ctrlWrite & avs_writedata_i[CTRL_CLEAR];
    assign irqEnLoad  = ctrlWrite & (avs_writedata_i[CTRL_ARM] |
                        (avs_writedata_i[CTRL_CLEAR:CTRL_ABORT] == 2'b00));

    // A pixel arriving with arm lands at address 0; one arriving with abort is dropped.
    assign capturing = arm | ((state == ST_CAPTURE) & ~abort);
    assign accept    = pixelValid_i & capturing;
    assign wrAddr    = arm ? '0 : count;
    assign lastPix   = (wrAddr == LAST_PIX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= ST_IDLE;
            count   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            irqEn   <= 1'b0;
        end else begin
            if (irqEnLoad) begin
                irqEn <= avs_writedata_i[CTRL_IRQEN];
            end
            if (clearFlags) begin
                done    <= 1'b0;
                overrun <= 1'b0;
            end
            if (pixelValid_i && !arm && state != ST_CAPTURE) begin
                overrun <= 1'b1;
            end
            if (arm) begin
                state   <= ST_CAPTURE;
                count   <= '0;
                done    <= 1'b0;
                overrun <= 1'b0;
            end else if (abort) begin
                state <= ST_IDLE;
            end
            if (accept) begin
                count <= wrAddr + 1'b1;
                if (lastPix) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
            end
        end
    end

    assign pixRel    = {1'b0, avs_address_i} - PIX_OFS;
    assign addrIsPix = (avs_address_i >= ADDR_PIX) && (pixRel < PIX_WORDS);

    always_comb begin
        statusWord                              = '0;
        statusWord[STATUS_BUSY]                 = (state == ST_CAPTURE);
        statusWord[STATUS_DONE]                 = done;
        statusWord[STATUS_OVERRUN]              = overrun;
        statusWord[STATUS_IRQEN]                = irqEn;
        statusWord[STATUS_COUNT_LSB +: CW]      = count;
    end

    always_comb begin
        regMux = '0;
        if (avs_address_i == ADDR_STAT) begin
            regMux = statusWord;
        end else if (avs_address_i == ADDR_SIZE) begin
            regMux = SIZE_WORD;
        end
    end

    // Register-side read data is captured alongside the RAM read so both
    // sources present with the same one-cycle latency.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            readValid <= 1'b0;
            readIsPix <= 1'b0;
            regData   <= '0;
        end else begin
            readValid <= avs_read_i;
            readIsPix <= avs_read_i & addrIsPix;
            if (avs_read_i) begin
                regData <= regMux;
            end
        end
    end

    frame_ram_sdp #(
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) uFrameRam (
        .clk    (clk_i),
        .wrEn   (accept),
        .wrAddr (RAM_AW'(wrAddr >> 2)),
        .byteEn (4'b0001 << wrAddr[1:0]),
        .wrData ({4{pixel_i}}),
        .rdEn   (avs_read_i & addrIsPix),
        .rdAddr (RAM_AW'(pixRel)),
        .rdData (ramData)
    );

    assign avs_readdata_o      = readIsPix ? ramData : regData;
    assign avs_readdatavalid_o = readValid;
    assign avs_waitrequest_o   = 1'b0;
    assign busy_o              = (state == ST_CAPTURE);
    assign irq_o               = done & irqEn;

endmodule

// File: tb/tb_edge_frame_collector.sv
// Directed bench for edge_frame_collector on a 4x4 frame with a byte model
// of the frame buffer and hand-computed register values.
module tb_edge_frame_collector;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          start = 1'b0;
    logic          pixValid = 1'b0;
    logic [7:0]    pix = 8'h00;
    logic [AW-1:0] avAddr = '0;
    logic          avRd = 1'b0;
    logic          avWr = 1'b0;
    logic [31:0]   avWdata = '0;
    logic [31:0]   readData;
    logic          readValid;
    logic          waitReq;
    logic          busy;
    logic          irq;

    int errors = 0;
    int checks = 0;
    int busyCycles;
    logic [7:0] model [16];

    edge_frame_collector #(
        .IMG_X_SIZE (4),
        .IMG_Y_SIZE (4),
        .AV_ADDR_W  (AW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rstN),
        .start_i             (start),
        .pixelValid_i        (pixValid),
        .pixel_i             (pix),
        .avs_address_i       (avAddr),
        .avs_read_i          (avRd),
        .avs_write_i         (avWr),
        .avs_writedata_i     (avWdata),
        .avs_readdata_o      (readData),
        .avs_readdatavalid_o (readValid),
        .avs_waitrequest_o   (waitReq),
        .busy_o              (busy),
        .irq_o               (irq)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic avWrite(input logic [AW-1:0] addr, input logic [31:0] data);
        avAddr  = addr;
        avWdata = data;
        avWr    = 1'b1;
        @(posedge clk);
        #1;
        avWr = 1'b0;
    endtask

    task automatic avReadWord(input logic [AW-1:0] addr, output logic [31:0] data, output int lat);
        avAddr = addr;
        avRd   = 1'b1;
        @(posedge clk);
        #1;
        avRd = 1'b0;
        lat  = 1;
        while (!readValid && lat < 4) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = readData;
    endtask

    task automatic checkRead(input string tag, input logic [AW-1:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        int lat;
        avReadWord(addr, data, lat);
        checkOutput({tag, " latency"}, lat, 1);
        checkOutput(tag, data, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] first, input int num, input int step);
        for (int i = 0; i < num; i++) begin
            pixValid = 1'b1;
            pix      = 8'(int'(first) + i * step);
            if (busy) busyCycles++;
            @(posedge clk);
            #1;
        end
        pixValid = 1'b0;
    endtask

    task automatic checkFrame(input string prefix);
        for (int w = 0; w < 4; w++) begin
            checkRead($sformatf("%s word%0d", prefix, w), AW'(4 + w),
                      {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]});
        end
    endtask

    initial begin
        int reads;
        int valids;
        int pairBad;
        int sent;
        logic prevRd;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset irq", irq, 0);
        checkOutput("reset rdvalid", readValid, 0);
        checkOutput("reset rddata", readData, 0);
        checkOutput("waitrequest", waitReq, 0);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkRead("status after reset", 0, 32'h0000_0000);
        checkRead("size", 1, 32'h0004_0004);

        // Full frame with irq enabled.
        avWrite(0, 32'h9);
        for (int i = 0; i < 16; i++) model[i] = 8'(i);
        busyCycles = 0;
        applyStimulus(8'h00, 16, 1);
        checkOutput("busy cycles frame1", busyCycles, 16);
        checkOutput("busy after frame1", busy, 0);
        checkOutput("irq after frame1", irq, 1);
        checkRead("status frame1", 0, 32'h0010_000A);
        checkFrame("frame1");
        checkRead("reserved addr2", 2, 32'h0);
        checkRead("beyond pixels", 8, 32'h0);

        // Pixels while DONE are dropped and flag overrun.
        applyStimulus(8'h55, 2, 1);
        checkRead("status overrun", 0, 32'h0010_000E);
        checkFrame("after overrun");
        avWrite(0, 32'h4);
        checkRead("status cleared", 0, 32'h0010_0008);
        checkOutput("irq cleared", irq, 0);

        // Abort keeps count; hardware start re-arms.
        avWrite(0, 32'h9);
        applyStimulus(8'hA0, 5, 1);
        for (int i = 0; i < 5; i++) model[i] = 8'(8'hA0 + i);
        avWrite(0, 32'h2);
        checkOutput("busy after abort", busy, 0);
        checkRead("status aborted", 0, 32'h0005_0008);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy after start", busy, 1);
        checkRead("status rearmed", 0, 32'h0000_0009);

        // Gapped pixels under back-to-back reads.
        for (int i = 0; i < 16; i++) model[i] = 8'(8'h40 + 5 * i);
        reads = 0; valids = 0; pairBad = 0; sent = 0;
        for (int c = 0; c < 28; c++) begin
            avRd   = (c < 20);
            avAddr = AW'(4 + c % 4);
            if (c % 3 != 2 && sent < 16) begin
                pixValid = 1'b1;
                pix      = model[sent];
                sent++;
            end else begin
                pixValid = 1'b0;
            end
            prevRd = avRd;
            if (avRd) reads++;
            @(posedge clk);
            #1;
            if (readValid) valids++;
            if (readValid != prevRd) pairBad++;
        end
        avRd = 1'b0;
        pixValid = 1'b0;
        checkOutput("rdvalid count", valids, reads);
        checkOutput("rdvalid pairing", pairBad, 0);
        checkRead("status gapped", 0, 32'h0010_000A);
        checkFrame("gapped");

        // Reset in the middle of a frame.
        avWrite(0, 32'h1);
        applyStimulus(8'h30, 6, 1);
        pixValid = 1'b1;
        pix      = 8'h36;
        avRd     = 1'b1;
        avAddr   = 0;
        @(posedge clk);
        #1;
        avRd = 1'b0;
        pix  = 8'h37;
        checkOutput("status before reset", readData, 32'h0006_0001);
        checkOutput("rdvalid before reset", readValid, 1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset irq", irq, 0);
        checkOutput("midreset rdvalid", readValid, 0);
        checkOutput("midreset rddata", readData, 0);
        pixValid = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkRead("status after midreset", 0, 32'h0);
        avWrite(0, 32'h1);
        for (int i = 0; i < 16; i++) model[i] = 8'(8'hF0 - i);
        busyCycles = 0;
        applyStimulus(8'hF0, 16, -1);
        checkOutput("busy cycles frame3", busyCycles, 16);
        checkRead("status frame3", 0, 32'h0010_0002);
        checkOutput("irq frame3", irq, 0);
        checkFrame("frame3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
